seg_scan_ctrl: RTL

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_pkg.sv | 23 ++
 rtl/seg_scan_ctrl_if.sv | 12 +
 rtl/hex7seg.sv | 14 +
 rtl/seg_scan_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the eight-digit seven-segment scanner:
// FSM states, blank levels and the hex-to-segment table.
package seg_pkg;

  typedef enum logic [0:0] {
    DRIVE = 1'b0,
    GUARD = 1'b1
  } scan_state_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // Active-low {g,f,e,d,c,b,a}; entry 15 first so HEX_TABLE[v] is the glyph for v.
  localparam logic [15:0][6:0] HEX_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] hex_lookup(input logic [3:0] value);
    return HEX_TABLE[value];
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Digit write bus of the seven-segment scanner: one 4-bit digit per strobe,
// no back-pressure.
interface seg_scan_ctrl_if;

  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);

endinterface

// File: rtl/hex7seg.sv
// Combinational 4-bit hex to active-low seven-segment decode.
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // table lookup, no state
  always_comb begin
    seg = hex_lookup(hex);
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scanner with per-slot blanking guard.
// Optional build macro SEG_LEADING_ZERO_BLANK_EN suppresses leading zeros.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int GUARD_CYC = 1000
) (
  input  logic              CLK100MHZ,
  input  logic              rst,
  seg_scan_ctrl_if.slave    wr,
  output logic [6:0]        seg,
  output logic [7:0]        AN,
  output logic              frame_done
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_ZERO   = CW'(0);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] DRIVE_LAST = CW'(SCAN_DIV - GUARD_CYC - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(SCAN_DIV - 1);

  scan_state_e   state_r, state_nx_s;
  logic [CW-1:0] cnt_r, cnt_nx_s;
  logic [2:0]    idx_r, idx_nx_s;
  logic          enter_s;
  logic          frame_s;

  logic [3:0]    digit_r    [8];
  logic [3:0]    digit_nx_s [8];
  logic [3:0]    shadow_r;
  logic [6:0]    dec_s;
  logic [6:0]    seg_nx_s;
  logic [7:0]    an_nx_s;

  // digit bank with the current write folded in, so a snapshot sees it too
  always_comb begin
    digit_nx_s = digit_r;
    if (wr.wr_en) begin
      digit_nx_s[wr.wr_addr] = wr.wr_data;
    end else begin
      digit_nx_s = digit_r;
    end
  end

  // digit register bank
  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) digit_r[i] <= 4'h0;
    end else begin
      digit_r <= digit_nx_s;
    end
  end

  // scan FSM state register
  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      state_r <= DRIVE;
      cnt_r   <= CNT_ZERO;
      idx_r   <= 3'd0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      idx_r   <= idx_nx_s;
    end
  end

  // scan FSM next state; cnt runs through both phases of a slot
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r + CNT_ONE;
    idx_nx_s   = idx_r;
    enter_s    = 1'b0;
    frame_s    = 1'b0;
    case (state_r)
      DRIVE: begin
        if (cnt_r == DRIVE_LAST) begin
          state_nx_s = GUARD;
        end else begin
          state_nx_s = DRIVE;
        end
      end
      GUARD: begin
        if (cnt_r == SLOT_LAST) begin
          state_nx_s = DRIVE;
          cnt_nx_s   = CNT_ZERO;
          idx_nx_s   = idx_r + 3'd1;
          enter_s    = 1'b1;
          frame_s    = (idx_r == 3'd7);
        end else begin
          state_nx_s = GUARD;
        end
      end
      default: begin
        state_nx_s = DRIVE;
        cnt_nx_s   = CNT_ZERO;
        idx_nx_s   = 3'd0;
      end
    endcase
  end

  // slot snapshot, so mid-slot writes wait for the digit's next slot
  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      shadow_r <= 4'h0;
    end else if (enter_s) begin
      shadow_r <= digit_nx_s[idx_nx_s];
    end else begin
      shadow_r <= shadow_r;
    end
  end

  hex7seg u_dec (
    .hex (shadow_r),
    .seg (dec_s)
  );

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic [7:0] zero_run_s;
  logic       blank_r;

  // zero_run_s[k]: digit k and every digit above it are zero
  always_comb begin
    zero_run_s    = 8'h00;
    zero_run_s[7] = (digit_nx_s[7] == 4'h0);
    for (int j = 6; j >= 0; j--) begin
      zero_run_s[j] = zero_run_s[j+1] && (digit_nx_s[j] == 4'h0);
    end
  end

  // blank decision captured with the snapshot; digit 0 always shows
  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      blank_r <= 1'b0;
    end else if (enter_s) begin
      blank_r <= (idx_nx_s != 3'd0) && zero_run_s[idx_nx_s];
    end else begin
      blank_r <= blank_r;
    end
  end

  // drive-phase glyph, blanked for leading zeros
  always_comb begin
    if (blank_r) begin
      seg_nx_s = SEG_OFF;
    end else begin
      seg_nx_s = dec_s;
    end
  end
`else
  // drive-phase glyph
  always_comb begin
    seg_nx_s = dec_s;
  end
`endif

  // display levels derived from the state, registered below
  always_comb begin
    an_nx_s = AN_OFF;
    case (state_r)
      DRIVE:   an_nx_s = ~(8'b0000_0001 << idx_r);
      GUARD:   an_nx_s = AN_OFF;
      default: an_nx_s = AN_OFF;
    endcase
  end

  // output registers, one cycle behind the FSM
  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      AN         <= AN_OFF;
      seg        <= SEG_OFF;
      frame_done <= 1'b0;
    end else begin
      AN         <= an_nx_s;
      seg        <= (state_r == DRIVE) ? seg_nx_s : SEG_OFF;
      frame_done <= frame_s;
    end
  end

endmodule
